cfg_initiator: RTL and testbench

- Host-side counterpart of the main controller's configuration receiver.
- On request, drives the configuration handshake over the byte-level UART TX/RX datapath:
  - sends SYN (8'h16), then one configuration packet per setting, then an end-configuration packet;
  - waits for the acknowledge byte (8'hFF) after every transmitted byte.
- Sits between the host control logic and the UART transmitter/receiver byte interfaces.
- Reports completion, or failure after bounded retries.

---
 rtl/cfg_initiator.sv | 153 +++++++++++++++
 tb/tb_cfg_initiator.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_initiator.sv
// cfg_initiator: host-side driver of the UART configuration handshake.
// Sends SYN, DW, PAR, STOP, END packets, each waiting for an 8'hFF ACK.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i, cfg_i          begin sequence; {data_width, parity, stop_bits}
//   tx_data_o/valid/ready   byte stream towards the UART transmitter
//   rx_data_i, rx_valid_i   byte strobe from the UART receiver
//   busy_o, done_o, error_o sequence status (done pulse, sticky error)
module cfg_initiator #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [5:0] cfg_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] R_MAX   = RW'(MAX_RETRIES);

    localparam logic [7:0] SYN_BYTE = 8'h16;
    localparam logic [7:0] ACK_BYTE = 8'hFF;
    localparam logic [2:0] LAST_IDX = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_RETRY,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    cfg_q, cfg_d;
    logic          err_q, err_d;
    logic [7:0]    cur_byte;

    // Packet layout is {4'b0000, option[1:0], id[1:0]}.
    always_comb begin
        cur_byte = 8'h00;
        unique case (idx_q)
            3'd0:    cur_byte = SYN_BYTE;
            3'd1:    cur_byte = {4'b0000, cfg_q[5:4], 2'b01};
            3'd2:    cur_byte = {4'b0000, cfg_q[3:2], 2'b10};
            3'd3:    cur_byte = {4'b0000, cfg_q[1:0], 2'b11};
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        cfg_d   = cfg_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cfg_d   = cfg_i;
                    err_d   = 1'b0;
                    idx_d   = 3'd0;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ready_i) begin
                    tmo_d   = '0;
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tmo_q != TO_MAX) begin
                    tmo_d = tmo_q + TW'(1);
                end
                // A reply in the final wait cycle beats the timeout.
                if (rx_valid_i) begin
                    if (rx_data_i == ACK_BYTE) begin
                        retry_d = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_RETRY;
                    end
                end else if (tmo_q == TO_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q == R_MAX) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = S_SEND;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            retry_q <= '0;
            tmo_q   <= '0;
            cfg_q   <= 6'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            cfg_q   <= cfg_d;
            err_q   <= err_d;
        end
    end

    assign tx_valid_o = (state_q == S_SEND);
    assign tx_data_o  = tx_valid_o ? cur_byte : 8'h00;
    assign busy_o     = (state_q == S_SEND) || (state_q == S_WAIT_ACK) ||
                        (state_q == S_RETRY);
    assign done_o     = (state_q == S_DONE);
    assign error_o    = err_q;

endmodule

// File: tb/tb_cfg_initiator.sv
// tb_cfg_initiator: scoreboard bench for cfg_initiator.
// Expected TX bytes are queued at start, popped on each handshake.
module tb_cfg_initiator;

    localparam int TO = 20;
    localparam int MR = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [5:0] cfg_i;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       busy_o;
    logic       done_o;
    logic       error_o;

    cfg_initiator #(
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .cfg_i     (cfg_i),
        .tx_data_o (tx_data_o),
        .tx_valid_o(tx_valid_o),
        .tx_ready_i(tx_ready_i),
        .rx_data_i (rx_data_i),
        .rx_valid_i(rx_valid_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .error_o   (error_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];
    int hs_time[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (!rst_i && tx_valid_o && tx_ready_i) begin
            hs_cnt++;
            hs_time.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("tx_unexpected_q", exp_q.size(), 1);
            end else begin
                chk("tx_byte", {24'd0, tx_data_o}, {24'd0, exp_q.pop_front()});
            end
        end
        if (done_o) done_cnt++;
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_seq(input logic [5:0] c);
        exp_q.push_back(8'h16);
        exp_q.push_back({4'b0000, c[5:4], 2'b01});
        exp_q.push_back({4'b0000, c[3:2], 2'b10});
        exp_q.push_back({4'b0000, c[1:0], 2'b11});
        exp_q.push_back(8'h00);
    endtask

    task automatic do_start(input logic [5:0] c);
        cfg_i   = c;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_hs;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (tx_valid_o && tx_ready_i) ok = 1'b1;
            tick();
        end
        chk("hs_wait", 32'(ok), 1);
    endtask

    // Called right after wait_hs: reply in wait cycle d-1.
    task automatic ack_after(input int d, input logic [7:0] b);
        repeat (d - 1) tick();
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        tick();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
    endtask

    task automatic run_all_acked;
        for (int k = 0; k < 5; k++) begin
            wait_hs();
            ack_after(2, 8'hFF);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int hb;
        bit stable;
        rst_i      = 1'b1;
        start_i    = 1'b0;
        cfg_i      = 6'd0;
        tx_ready_i = 1'b1;
        rx_data_i  = 8'h00;
        rx_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_tx_valid", 32'(tx_valid_o), 0);
        chk("rst_tx_data", 32'(tx_data_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_o), 0);
        chk("rst_error", 32'(error_o), 0);
        rst_i = 1'b0;
        tick();

        // nominal, plus start_i while busy
        push_seq(6'b10_01_11);
        do_start(6'b10_01_11);
        chk("nom_busy", 32'(busy_o), 1);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        start_i = 1'b1;
        cfg_i   = 6'b00_00_00;
        ack_after(2, 8'hFF);
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_hs();
            ack_after(2, 8'hFF);
        end
        tick();
        tick();
        chk("nom_done_cnt", done_cnt, 1);
        chk("nom_busy_end", 32'(busy_o), 0);
        chk("nom_error", 32'(error_o), 0);
        chk("nom_q_empty", exp_q.size(), 0);

        // stray ACK in IDLE
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hFF;
        tick();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tick();
        chk("idle_rx_busy", 32'(busy_o), 0);
        chk("idle_rx_txv", 32'(tx_valid_o), 0);
        chk("idle_rx_done", done_cnt, 1);

        // NACK on PAR once
        exp_q.push_back(8'h16);
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h00);
        do_start(6'b01_10_00);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        ack_after(2, 8'h55);
        for (int k = 0; k < 3; k++) begin
            wait_hs();
            ack_after(2, 8'hFF);
        end
        tick();
        tick();
        chk("nack_done_cnt", done_cnt, 2);
        chk("nack_error", 32'(error_o), 0);
        chk("nack_q_empty", exp_q.size(), 0);

        // backpressure on STOP, then ACK on the timeout cycle for END
        push_seq(6'b11_00_01);
        do_start(6'b11_00_01);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        tick();
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hFF;
        tx_ready_i = 1'b0;
        tick();
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        hb = hs_cnt;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (!(tx_valid_o && tx_data_o == 8'h07 && busy_o)) stable = 1'b0;
            tick();
        end
        chk("bp_hold", 32'(stable), 1);
        chk("bp_no_hs", hs_cnt, hb);
        tx_ready_i = 1'b1;
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        ack_after(TO, 8'hFF);
        tick();
        tick();
        chk("bp_done_cnt", done_cnt, 3);
        chk("bp_q_empty", exp_q.size(), 0);
        chk("bp_error", 32'(error_o), 0);

        // timeout exhaustion on SYN
        repeat (MR + 1) exp_q.push_back(8'h16);
        n0 = hs_time.size();
        do_start(6'b00_00_00);
        for (int i = 0; i < 300 && !error_o; i++) tick();
        chk("to_error", 32'(error_o), 1);
        chk("to_syn_count", hs_time.size() - n0, MR + 1);
        if (hs_time.size() >= n0 + 3) begin
            chk("to_gap1", hs_time[n0+1] - hs_time[n0], TO + 2);
            chk("to_gap2", hs_time[n0+2] - hs_time[n0+1], TO + 2);
        end
        tick();
        tick();
        chk("to_busy", 32'(busy_o), 0);
        chk("to_no_done", done_cnt, 3);
        chk("to_err_sticky", 32'(error_o), 1);
        chk("to_q_empty", exp_q.size(), 0);

        // new start clears error; reset during DW wait
        exp_q.push_back(8'h16);
        exp_q.push_back(8'h09);
        do_start(6'b10_10_10);
        chk("clr_error", 32'(error_o), 0);
        wait_hs();
        ack_after(2, 8'hFF);
        wait_hs();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_txv", 32'(tx_valid_o), 0);
        chk("mid_rst_txd", 32'(tx_data_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 0);
        chk("mid_rst_done", 32'(done_o), 0);
        chk("mid_rst_error", 32'(error_o), 0);
        hb = hs_cnt;
        repeat (30) tick();
        chk("mid_rst_quiet", hs_cnt, hb);
        chk("mid_rst_q", exp_q.size(), 0);
        push_seq(6'b10_10_10);
        do_start(6'b10_10_10);
        run_all_acked();
        tick();
        tick();
        chk("restart_done", done_cnt, 4);
        chk("restart_q", exp_q.size(), 0);
        chk("restart_busy", 32'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
